// File: rtl/crc_pkg.sv
// Shared CRC helpers: serial byte step, bit reversal, FSM states and standard presets.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    APPEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic        refin;
    logic        refout;
    logic [31:0] xorout;
  } crc_preset_t;

  localparam crc_preset_t MODBUS      = '{poly: 32'h0000_8005, init: 32'h0000_FFFF,
                                          refin: 1'b1, refout: 1'b1, xorout: 32'h0};
  localparam crc_preset_t CCITT_FALSE = '{poly: 32'h0000_1021, init: 32'h0000_FFFF,
                                          refin: 1'b0, refout: 1'b0, xorout: 32'h0};
  localparam crc_preset_t CRC32       = '{poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
                                          refin: 1'b1, refout: 1'b1, xorout: 32'hFFFF_FFFF};

  // Reverses the low 'width' bits of vec; upper bits of the result are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] vec, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = vec[width-1-i];
    end
    return r;
  endfunction

  // Eight MSB-first shift/XOR steps of a width-bit CRC register.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [7:0] data,
                                                input logic [31:0] poly, input int width);
    logic [31:0] c;
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    c    = crc & mask;
    for (int i = 7; i >= 0; i--) begin
      fb = c[width-1] ^ data[i];
      c  = (c << 1) & mask;
      if (fb) c = c ^ (poly & mask);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_byte_engine.sv
// Combinational next-CRC for one byte; shared between the TX appender and the RX checker.
module crc_byte_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = 16'h8005,
  parameter bit               REFIN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc_next
);

  logic [31:0] data_rev;
  logic [7:0]  data_ord;
  logic [31:0] step;

  always_comb begin
    data_rev = bit_reverse({24'd0, data_in}, 8);
    data_ord = REFIN ? data_rev[7:0] : data_in;
    step     = crc_byte_step(32'(crc_in), data_ord, 32'(POLY), CRC_W);
    crc_next = CRC_W'(step);
  end

endmodule

// File: rtl/crc_frame_appender.sv
// Passes byte frames through a single output register and appends the frame CRC.
//   state  | meaning
//   IDLE   | waiting for the first byte of a frame
//   DATA   | mid-frame, payload bytes flowing through
//   APPEND | payload done, loading CRC bytes into the output register
module crc_frame_appender
  import crc_pkg::*;
#(
  parameter int               CRC_W     = 16,
  parameter logic [CRC_W-1:0] POLY      = 16'h8005,
  parameter logic [CRC_W-1:0] INIT      = 16'hFFFF,
  parameter bit               REFIN     = 1'b1,
  parameter bit               REFOUT    = 1'b1,
  parameter logic [CRC_W-1:0] XOROUT    = 16'h0000,
  parameter bit               MSB_FIRST = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       s_data_in,
  input  logic             s_valid_in,
  input  logic             s_last_in,
  output logic             s_ready_out,
  output logic [7:0]       m_data_out,
  output logic             m_valid_out,
  output logic             m_last_out,
  input  logic             m_ready_in,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_valid_out,
  output logic             busy_out
);

  localparam int NB = CRC_W / 8;

  if (!(CRC_W == 8 || CRC_W == 16 || CRC_W == 32)) begin : g_bad_width
    $error("crc_frame_appender: CRC_W must be 8, 16 or 32");
  end

  state_t           state;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_fin;
  logic [31:0]      crc_rev;
  logic [1:0]       k;
  logic [7:0]       crc_byte;
  int               byte_idx;
  logic             accept;
  logic             out_free;

  crc_byte_engine #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .REFIN (REFIN)
  ) u_engine (
    .crc_in   (crc_reg),
    .data_in  (s_data_in),
    .crc_next (crc_next)
  );

  assign out_free    = !m_valid_out || m_ready_in;
  assign s_ready_out = (state != APPEND) && out_free;
  assign accept      = s_valid_in && s_ready_out;

  // Final CRC is formed from the engine output so the last payload byte is included.
  always_comb begin
    crc_rev = bit_reverse(32'(crc_next), CRC_W);
    crc_fin = (REFOUT ? CRC_W'(crc_rev) : crc_next) ^ XOROUT;
  end

  always_comb begin
    byte_idx = MSB_FIRST ? (NB - 1 - int'(k)) : int'(k);
    crc_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (i == byte_idx) crc_byte = crc_out[8*i +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      crc_reg       <= INIT;
      k             <= '0;
      m_data_out    <= '0;
      m_valid_out   <= 1'b0;
      m_last_out    <= 1'b0;
      crc_out       <= '0;
      crc_valid_out <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      crc_valid_out <= 1'b0;

      if (accept) busy_out <= 1'b1;
      else if (m_valid_out && m_ready_in && m_last_out) busy_out <= 1'b0;

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            m_data_out  <= s_data_in;
            m_valid_out <= 1'b1;
            m_last_out  <= 1'b0;
            if (s_last_in) begin
              crc_out       <= crc_fin;
              crc_valid_out <= 1'b1;
              crc_reg       <= INIT;
              k             <= '0;
              state         <= APPEND;
            end else begin
              crc_reg <= crc_next;
              state   <= DATA;
            end
          end else if (m_ready_in) begin
            m_valid_out <= 1'b0;
            m_last_out  <= 1'b0;
          end
        end
        APPEND: begin
          // Leaving on the load of the final CRC byte keeps the inter-frame gap at NB cycles.
          if (out_free) begin
            m_data_out  <= crc_byte;
            m_valid_out <= 1'b1;
            m_last_out  <= (k == 2'(NB - 1));
            if (k == 2'(NB - 1)) begin
              k     <= '0;
              state <= IDLE;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_appender.sv
// Scoreboard bench: MODBUS instance for the main flow, CCITT-FALSE and CRC-32 instances for the check vectors.
module tb_crc_frame_appender;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_in;
  logic [7:0] s_data;
  logic       s_valid, s_last;
  logic       en_b;
  logic       rand_mode;
  logic       ready_fixed;
  logic       m_ready0 = 1'b1;
  logic       one = 1'b1;

  logic        s_ready0, m_valid0, m_last0, crc_valid0, busy0;
  logic [7:0]  m_data0;
  logic [15:0] crc_out0;
  logic        s_ready1, m_valid1, m_last1, crc_valid1, busy1;
  logic [7:0]  m_data1;
  logic [15:0] crc_out1;
  logic        s_ready2, m_valid2, m_last2, crc_valid2, busy2;
  logic [7:0]  m_data2;
  logic [31:0] crc_out2;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];
  logic [7:0] frame[$];

  int          strobes0 = 0, strobes1 = 0, strobes2 = 0;
  logic [15:0] last_crc0 = '0, last_crc1 = '0;
  logic [31:0] last_crc2 = '0;
  logic [15:0] exp_crc0;
  logic        stall0 = 1'b0;
  logic [8:0]  stall_v0;

  crc_frame_appender #(
    .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .REFIN(1'b1), .REFOUT(1'b1),
    .XOROUT(16'h0000), .MSB_FIRST(1'b0)
  ) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .s_data_in(s_data), .s_valid_in(s_valid),
    .s_last_in(s_last), .s_ready_out(s_ready0), .m_data_out(m_data0), .m_valid_out(m_valid0),
    .m_last_out(m_last0), .m_ready_in(m_ready0), .crc_out(crc_out0),
    .crc_valid_out(crc_valid0), .busy_out(busy0)
  );

  crc_frame_appender #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .REFIN(1'b0), .REFOUT(1'b0),
    .XOROUT(16'h0000), .MSB_FIRST(1'b1)
  ) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .s_data_in(s_data), .s_valid_in(s_valid && en_b),
    .s_last_in(s_last), .s_ready_out(s_ready1), .m_data_out(m_data1), .m_valid_out(m_valid1),
    .m_last_out(m_last1), .m_ready_in(one), .crc_out(crc_out1),
    .crc_valid_out(crc_valid1), .busy_out(busy1)
  );

  crc_frame_appender #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
    .XOROUT(32'hFFFFFFFF), .MSB_FIRST(1'b0)
  ) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .s_data_in(s_data), .s_valid_in(s_valid && en_b),
    .s_last_in(s_last), .s_ready_out(s_ready2), .m_data_out(m_data2), .m_valid_out(m_valid2),
    .m_last_out(m_last2), .m_ready_in(one), .crc_out(crc_out2),
    .crc_valid_out(crc_valid2), .busy_out(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference MODBUS in its reflected (LSB-first, poly 0xA001) form.
  function automatic logic [15:0] modbus_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always @(posedge clk_in) begin
    #1;
    m_ready0 = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  always @(negedge clk_in) begin : mon0
    exp_t e;
    if (rst_in) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) chk("hold_while_stalled", {22'd0, m_valid0, m_last0, m_data0}, {22'd0, 1'b1, stall_v0});
      if (m_valid0 && m_ready0) begin
        if (q0.size() > 0) e = q0.pop_front();
        else e = 9'bx;
        chk("out0_byte", {23'd0, m_last0, m_data0}, {23'd0, e});
      end
      stall0   = m_valid0 && !m_ready0;
      stall_v0 = {m_last0, m_data0};
      if (crc_valid0) begin
        strobes0++;
        last_crc0 = crc_out0;
      end
    end
  end

  always @(negedge clk_in) begin : mon12
    exp_t e;
    if (!rst_in) begin
      if (m_valid1) begin
        if (q1.size() > 0) e = q1.pop_front();
        else e = 9'bx;
        chk("out1_byte", {23'd0, m_last1, m_data1}, {23'd0, e});
      end
      if (m_valid2) begin
        if (q2.size() > 0) e = q2.pop_front();
        else e = 9'bx;
        chk("out2_byte", {23'd0, m_last2, m_data2}, {23'd0, e});
      end
      if (crc_valid1) begin strobes1++; last_crc1 = crc_out1; end
      if (crc_valid2) begin strobes2++; last_crc2 = crc_out2; end
    end
  end

  // Entered and left at posedge+1; stalls counts negedges spent waiting for s_ready.
  task automatic send_byte(input logic [7:0] d, input logic l, output int stalls);
    int g;
    stalls = 0;
    if (rand_mode) begin
      s_valid = 1'b0;
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk_in); #1; end
    end
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    @(negedge clk_in);
    while (!(s_ready0 && (!en_b || (s_ready1 && s_ready2))) && stalls < 1000) begin
      stalls++;
      @(negedge clk_in);
    end
    if (stalls >= 1000) begin
      chk("accept_timeout", {31'd0, s_ready0}, 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk_in);
    q0.push_back({1'b0, d});
    if (en_b) begin
      q1.push_back({1'b0, d});
      q2.push_back({1'b0, d});
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(output int first_stalls);
    logic [15:0] c;
    int st;
    c = 16'hFFFF;
    first_stalls = 0;
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], (i == frame.size() - 1), st);
      if (i == 0) first_stalls = st;
      c = modbus_upd(c, frame[i]);
    end
    exp_crc0 = c;
    q0.push_back({1'b0, c[7:0]});
    q0.push_back({1'b1, c[15:8]});
    if (en_b) begin
      q1.push_back({1'b0, 8'h29}); q1.push_back({1'b1, 8'hB1});
      q2.push_back({1'b0, 8'h26}); q2.push_back({1'b0, 8'h39});
      q2.push_back({1'b0, 8'hF4}); q2.push_back({1'b1, 8'hCB});
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk_in);
    chk("drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    @(negedge clk_in);
  endtask

  task automatic load_123456789();
    frame.delete();
    for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    int st, st2, len;
    rst_in = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    en_b = 1'b0; rand_mode = 1'b0; ready_fixed = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_m_valid", {31'd0, m_valid0}, 32'd0);
    chk("rst_m_last", {31'd0, m_last0}, 32'd0);
    chk("rst_m_data", {24'd0, m_data0}, 32'd0);
    chk("rst_crc_out", {16'd0, crc_out0}, 32'd0);
    chk("rst_crc_out32", crc_out2, 32'd0);
    chk("rst_crc_valid", {31'd0, crc_valid0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready0}, 32'd1);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Reference vectors on all three presets at once.
    en_b = 1'b1;
    load_123456789();
    send_frame(st);
    en_b = 1'b0;
    chk("busy_in_append", {31'd0, busy0}, 32'd1);
    wait_drain();
    chk("modbus_crc", {16'd0, last_crc0}, 32'h4B37);
    chk("modbus_strobes", 32'(strobes0), 32'd1);
    chk("ccitt_crc", {16'd0, last_crc1}, 32'h29B1);
    chk("ccitt_strobes", 32'(strobes1), 32'd1);
    chk("crc32_crc", last_crc2, 32'hCBF43926);
    chk("crc32_strobes", 32'(strobes2), 32'd1);
    chk("busy_done", {29'd0, busy0, busy1, busy2}, 32'd0);

    // Single-byte frame followed immediately by another.
    @(posedge clk_in); #1;
    frame.delete();
    frame.push_back(8'h00);
    send_frame(st);
    send_frame(st2);
    chk("gap_cycles", 32'(st2), 32'd2);
    wait_drain();
    chk("single_crc", {16'd0, last_crc0}, 32'h40BF);
    chk("single_strobes", 32'(strobes0), 32'd3);

    // Abort mid-frame with reset, then resend.
    @(posedge clk_in); #1;
    load_123456789();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b0, st);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("abort_m_valid", {31'd0, m_valid0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_crc_out", {16'd0, crc_out0}, 32'd0);
    chk("abort_pending", 32'(q0.size()), 32'd0);
    chk("abort_strobes", 32'(strobes0), 32'd3);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    send_frame(st);
    wait_drain();
    chk("resend_crc", {16'd0, last_crc0}, 32'h4B37);
    chk("resend_strobes", 32'(strobes0), 32'd4);

    // Random frames with random backpressure and input gaps.
    @(posedge clk_in); #1;
    rand_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 64);
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
      send_frame(st);
    end
    rand_mode = 1'b0;
    wait_drain();
    chk("random_strobes", 32'(strobes0), 32'd104);
    chk("random_last_crc", {16'd0, last_crc0}, {16'd0, exp_crc0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
